// File: rtl/lin_rom_tt_probe.sv
// lin_rom_tt_probe
// Characterisation harness for an N-input, single-output combinational
// function. A run sweeps every input pattern and captures the response
// into a truth table while counting the onset. It then checks whether the
// function is invariant under XOR translation by a latched vector, and
// finally streams the truth table out one bit per valid/ready transfer.
//
// All outputs are registers. The FSM uses a two-process style: one
// always_comb block computes the next value of every register, and one
// always_ff block commits those values. The truth table storage has no
// reset, so it is written from its own clocked block.

module lin_rom_tt_probe #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] vec_a,
  output logic [N-1:0] x,
  input  logic         y,
  output logic         busy,
  output logic         done,
  output logic [N:0]   onset_cnt,
  output logic         invariant,
  output logic         tt_bit,
  output logic         tt_valid,
  input  logic         tt_ready
);

  localparam int           DEPTH    = 1 << N;
  localparam logic [N-1:0] IDX_ZERO = {N{1'b0}};
  localparam logic [N-1:0] IDX_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] IDX_LAST = {N{1'b1}};
  localparam logic [N:0]   CNT_ZERO = {(N+1){1'b0}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_CHECK   = 3'd2,
    S_STREAM  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Architectural state
  state_t           r_state;
  logic [N-1:0]     r_idx;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_x;
  logic [N:0]       r_onset;
  logic             r_inv;
  logic             r_busy;
  logic             r_done;
  logic             r_tt_bit;
  logic             r_tt_valid;
  logic [DEPTH-1:0] r_tt;

  // Next-state values
  state_t           w_state_nxt;
  logic [N-1:0]     w_idx_nxt;
  logic [N-1:0]     w_a_nxt;
  logic [N-1:0]     w_x_nxt;
  logic [N:0]       w_onset_nxt;
  logic             w_inv_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_tt_bit_nxt;
  logic             w_tt_valid_nxt;
  logic             w_tt_we;
  logic [N-1:0]     w_idx_inc;
  logic             w_idx_last;
  logic             w_mismatch;

  assign w_idx_inc  = r_idx + IDX_ONE;
  assign w_idx_last = (r_idx == IDX_LAST);
  // The table entry and its translated partner for the current CHECK step
  assign w_mismatch = (r_tt[r_idx] != r_tt[r_idx ^ r_a]);

  // Next-state and next-output computation for every register
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_a_nxt        = r_a;
    w_x_nxt        = r_x;
    w_onset_nxt    = r_onset;
    w_inv_nxt      = r_inv;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_tt_bit_nxt   = r_tt_bit;
    w_tt_valid_nxt = r_tt_valid;
    w_tt_we        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_nxt     = vec_a;
          w_onset_nxt = CNT_ZERO;
          w_inv_nxt   = 1'b1;
          w_idx_nxt   = IDX_ZERO;
          w_x_nxt     = IDX_ZERO;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_CAPTURE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_CAPTURE: begin
        // x already equals idx, so y is the response for this pattern
        w_tt_we     = 1'b1;
        w_onset_nxt = r_onset + {{N{1'b0}}, y};
        if (w_idx_last) begin
          w_idx_nxt   = IDX_ZERO;
          w_x_nxt     = IDX_ZERO;
          w_state_nxt = S_CHECK;
        end else begin
          w_idx_nxt = w_idx_inc;
          w_x_nxt   = w_idx_inc;
        end
      end

      S_CHECK: begin
        // Once cleared, invariant stays low for the remainder of the run
        if (w_mismatch) begin
          w_inv_nxt = 1'b0;
        end else begin
          w_inv_nxt = r_inv;
        end
        if (w_idx_last) begin
          // Present the first stream bit in the first STREAM cycle
          w_idx_nxt      = IDX_ZERO;
          w_tt_valid_nxt = 1'b1;
          w_tt_bit_nxt   = r_tt[IDX_ZERO];
          w_state_nxt    = S_STREAM;
        end else begin
          w_idx_nxt = w_idx_inc;
        end
      end

      S_STREAM: begin
        // tt_valid is always high here, so a transfer is just tt_ready
        if (tt_ready) begin
          if (w_idx_last) begin
            w_idx_nxt      = IDX_ZERO;
            w_tt_valid_nxt = 1'b0;
            w_tt_bit_nxt   = 1'b0;
            w_busy_nxt     = 1'b0;
            w_done_nxt     = 1'b1;
            w_state_nxt    = S_DONE;
          end else begin
            w_idx_nxt    = w_idx_inc;
            w_tt_bit_nxt = r_tt[w_idx_inc];
          end
        end else begin
          // Stalled: hold data and valid stable
          w_idx_nxt = r_idx;
        end
      end

      S_DONE: begin
        // start is deliberately not looked at in this cycle
        w_x_nxt     = IDX_ZERO;
        w_idx_nxt   = IDX_ZERO;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt    = S_IDLE;
        w_idx_nxt      = IDX_ZERO;
        w_x_nxt        = IDX_ZERO;
        w_busy_nxt     = 1'b0;
        w_tt_valid_nxt = 1'b0;
        w_tt_bit_nxt   = 1'b0;
      end
    endcase
  end

  // Commit FSM state and registered outputs; async reset discards any run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= IDX_ZERO;
      r_a        <= IDX_ZERO;
      r_x        <= IDX_ZERO;
      r_onset    <= CNT_ZERO;
      r_inv      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tt_bit   <= 1'b0;
      r_tt_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_a        <= w_a_nxt;
      r_x        <= w_x_nxt;
      r_onset    <= w_onset_nxt;
      r_inv      <= w_inv_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_tt_bit   <= w_tt_bit_nxt;
      r_tt_valid <= w_tt_valid_nxt;
    end
  end

  // Truth-table capture; contents survive reset and are overwritten each run
  always_ff @(posedge clk) begin
    if (w_tt_we) begin
      r_tt[r_idx] <= y;
    end
  end

  assign x         = r_x;
  assign busy      = r_busy;
  assign done      = r_done;
  assign onset_cnt = r_onset;
  assign invariant = r_inv;
  assign tt_bit    = r_tt_bit;
  assign tt_valid  = r_tt_valid;

endmodule

// File: tb/tb_lin_rom_tt_probe.sv
// Directed testbench for lin_rom_tt_probe. A small behavioural function
// block returns y from x. Each scenario task drives one run and compares
// the observations against hand-computed values.

module tb_lin_rom_tt_probe;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] vec_a;
  logic [6:0] x;
  logic       y;
  logic       busy;
  logic       done;
  logic [7:0] onset_cnt;
  logic       invariant;
  logic       tt_bit;
  logic       tt_valid;
  logic       tt_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int fmode    = 0;

  lin_rom_tt_probe #(.N(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_a     (vec_a),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .onset_cnt (onset_cnt),
    .invariant (invariant),
    .tt_bit    (tt_bit),
    .tt_valid  (tt_valid),
    .tt_ready  (tt_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function under characterisation
  always_comb begin
    case (fmode)
      0: y = 1'b0;
      1: y = x[0];
      2: y = x[0] ^ x[1];
      3: y = 1'b1;
      4: y = x[6];
      default: y = 1'b0;
    endcase
  end

  // Runs one start-to-done sequence and records what was observed.
  task automatic do_run(input int mode, input logic [6:0] va, input bit bp, input bit inj,
                        output int done_cyc, output int done_cnt,
                        output logic [7:0] onset_o, output logic inv_o,
                        output logic [127:0] bits, output int xfers, output int stalls,
                        output bit hold_ok, output bit x_ok, output bit busy_ok);
    int s;
    bit prev_stall;
    logic prev_bit;
    logic [6:0] xe;
    done_cyc = -1; done_cnt = 0; onset_o = 8'h00; inv_o = 1'b0;
    bits = 128'h0; xfers = 0; stalls = 0; hold_ok = 1'b1; x_ok = 1'b1; busy_ok = 1'b1;
    s = 0; prev_stall = 1'b0; prev_bit = 1'b0;
    fmode = mode; vec_a = va; tt_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      start = 1'b0;
      xe = 7'(c - 1);
      if (c <= 128 && x !== xe) x_ok = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          onset_o  = onset_cnt;
          inv_o    = invariant;
          if (x !== 7'h00) x_ok = 1'b0;
          if (busy !== 1'b0) busy_ok = 1'b0;
          if (inj) begin start = 1'b1; vec_a = 7'h01; end
        end
      end else if (done_cyc < 0) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
      end else begin
        if (busy !== 1'b0) busy_ok = 1'b0;
      end
      if (inj && (c == 50 || c == 200 || c == 300)) begin
        start = 1'b1;
        vec_a = 7'h01;
      end
      if (tt_valid === 1'b1) begin
        if (prev_stall && tt_bit !== prev_bit) hold_ok = 1'b0;
        tt_ready = bp ? ((s % 3) == 0) : 1'b1;
        s++;
        if (tt_ready) begin
          if (xfers < 128) bits[xfers] = tt_bit;
          xfers++;
          prev_stall = 1'b0;
        end else begin
          stalls++;
          prev_stall = 1'b1;
          prev_bit   = tt_bit;
        end
      end else begin
        tt_ready   = 1'b1;
        prev_stall = 1'b0;
      end
      if (done_cyc >= 0 && c >= done_cyc + 5) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    tt_ready = 1'b1;
    vec_a = va;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; vec_a = 7'h00; tt_ready = 1'b1; fmode = 0;
    #12;
    n_checks++;
    if (x !== 7'h00) begin n_fail++; $display("FAIL reset_x actual=%h required=00", x); end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_done actual=%b%b required=00", busy, done);
    end
    n_checks++;
    if (onset_cnt !== 8'h00 || invariant !== 1'b0) begin
      n_fail++; $display("FAIL reset_onset_inv actual=%h/%b required=00/0", onset_cnt, invariant);
    end
    n_checks++;
    if (tt_bit !== 1'b0 || tt_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_stream actual=%b%b required=00", tt_bit, tt_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int dc, dn, xf, st; logic [7:0] on; logic iv; logic [127:0] b; bit h, xo, bo;
    do_run(0, 7'h15, 1'b0, 1'b0, dc, dn, on, iv, b, xf, st, h, xo, bo);
    n_checks++;
    if (dc !== 385) begin n_fail++; $display("FAIL zero_done_cycle actual=%0d required=385", dc); end
    n_checks++;
    if (dn !== 1) begin n_fail++; $display("FAIL zero_done_count actual=%0d required=1", dn); end
    n_checks++;
    if (on !== 8'd0) begin n_fail++; $display("FAIL zero_onset actual=%0d required=0", on); end
    n_checks++;
    if (iv !== 1'b1) begin n_fail++; $display("FAIL zero_invariant actual=%b required=1", iv); end
    n_checks++;
    if (b !== 128'h0 || xf !== 128) begin
      n_fail++; $display("FAIL zero_stream actual=%h/%0d required=0/128", b, xf);
    end
    n_checks++;
    if (xo !== 1'b1) begin n_fail++; $display("FAIL zero_x_sweep actual=%b required=1", xo); end
    n_checks++;
    if (bo !== 1'b1) begin n_fail++; $display("FAIL zero_busy actual=%b required=1", bo); end
  endtask

  task automatic test_x0();
    int dc, dn, xf, st; logic [7:0] on; logic iv; logic [127:0] b; bit h, xo, bo;
    do_run(1, 7'h01, 1'b0, 1'b0, dc, dn, on, iv, b, xf, st, h, xo, bo);
    n_checks++;
    if (on !== 8'd64) begin n_fail++; $display("FAIL x0_a01_onset actual=%0d required=64", on); end
    n_checks++;
    if (iv !== 1'b0) begin n_fail++; $display("FAIL x0_a01_invariant actual=%b required=0", iv); end
    n_checks++;
    if (b !== {4{32'hAAAAAAAA}}) begin
      n_fail++; $display("FAIL x0_stream actual=%h required=%h", b, {4{32'hAAAAAAAA}});
    end
    do_run(1, 7'h02, 1'b0, 1'b0, dc, dn, on, iv, b, xf, st, h, xo, bo);
    n_checks++;
    if (on !== 8'd64) begin n_fail++; $display("FAIL x0_a02_onset actual=%0d required=64", on); end
    n_checks++;
    if (iv !== 1'b1) begin n_fail++; $display("FAIL x0_a02_invariant actual=%b required=1", iv); end
    n_checks++;
    if (dc !== 385) begin n_fail++; $display("FAIL x0_a02_done_cycle actual=%0d required=385", dc); end
  endtask

  task automatic test_xor_and_ones();
    int dc, dn, xf, st; logic [7:0] on; logic iv; logic [127:0] b; bit h, xo, bo;
    do_run(2, 7'h03, 1'b0, 1'b0, dc, dn, on, iv, b, xf, st, h, xo, bo);
    n_checks++;
    if (iv !== 1'b1 || on !== 8'd64) begin
      n_fail++; $display("FAIL xor_a03 actual=%b/%0d required=1/64", iv, on);
    end
    n_checks++;
    if (b !== {4{32'h66666666}}) begin
      n_fail++; $display("FAIL xor_stream actual=%h required=%h", b, {4{32'h66666666}});
    end
    do_run(2, 7'h00, 1'b0, 1'b0, dc, dn, on, iv, b, xf, st, h, xo, bo);
    n_checks++;
    if (iv !== 1'b1) begin n_fail++; $display("FAIL xor_a00_invariant actual=%b required=1", iv); end
    do_run(3, 7'h55, 1'b0, 1'b0, dc, dn, on, iv, b, xf, st, h, xo, bo);
    n_checks++;
    if (on !== 8'd128) begin n_fail++; $display("FAIL ones_onset actual=%0d required=128", on); end
    n_checks++;
    if (iv !== 1'b1 || b !== {128{1'b1}}) begin
      n_fail++; $display("FAIL ones_inv_stream actual=%b/%h required=1/all-ones", iv, b);
    end
  endtask

  task automatic test_backpressure();
    int dc, dn, xf, st; logic [7:0] on; logic iv; logic [127:0] b; bit h, xo, bo;
    // ready pattern 1,0,0 repeating: 127 gaps of 2 stalls = 254, done at 385+254
    do_run(4, 7'h40, 1'b1, 1'b0, dc, dn, on, iv, b, xf, st, h, xo, bo);
    n_checks++;
    if (h !== 1'b1) begin n_fail++; $display("FAIL bp_hold actual=%b required=1", h); end
    n_checks++;
    if (xf !== 128) begin n_fail++; $display("FAIL bp_transfers actual=%0d required=128", xf); end
    n_checks++;
    if (b !== {64'hFFFFFFFFFFFFFFFF, 64'h0}) begin
      n_fail++; $display("FAIL bp_stream actual=%h required=%h", b, {64'hFFFFFFFFFFFFFFFF, 64'h0});
    end
    n_checks++;
    if (st !== 254 || dc !== 639) begin
      n_fail++; $display("FAIL bp_latency actual=%0d/%0d required=254/639", st, dc);
    end
    n_checks++;
    if (on !== 8'd64 || iv !== 1'b0) begin
      n_fail++; $display("FAIL bp_onset_inv actual=%0d/%b required=64/0", on, iv);
    end
  endtask

  task automatic test_reset_mid();
    int dc, dn, xf, st; logic [7:0] on; logic iv; logic [127:0] b; bit h, xo, bo;
    bit seen, stray;
    fmode = 1; vec_a = 7'h02; tt_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (x === 7'd40) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rstmid_reach40 actual=%h required=28", x); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || x !== 7'h00) begin
      n_fail++; $display("FAIL rstmid_immediate actual=%b/%h required=0/00", busy, x);
    end
    n_checks++;
    if (onset_cnt !== 8'h00 || tt_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs actual=%h/%b/%b required=00/0/0", onset_cnt, tt_valid, done);
    end
    #2;
    rst = 1'b0;
    stray = 1'b0;
    for (int c = 0; c < 420; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    n_checks++;
    if (stray) begin n_fail++; $display("FAIL rstmid_no_done actual=1 required=0"); end
    do_run(1, 7'h02, 1'b0, 1'b0, dc, dn, on, iv, b, xf, st, h, xo, bo);
    n_checks++;
    if (on !== 8'd64 || dc !== 385) begin
      n_fail++; $display("FAIL rstmid_rerun actual=%0d/%0d required=64/385", on, dc);
    end
  endtask

  task automatic test_start_ignored();
    int dc, dn, xf, st; logic [7:0] on; logic iv; logic [127:0] b; bit h, xo, bo;
    do_run(1, 7'h02, 1'b0, 1'b1, dc, dn, on, iv, b, xf, st, h, xo, bo);
    n_checks++;
    if (dn !== 1) begin n_fail++; $display("FAIL ign_done_count actual=%0d required=1", dn); end
    n_checks++;
    if (dc !== 385) begin n_fail++; $display("FAIL ign_done_cycle actual=%0d required=385", dc); end
    n_checks++;
    if (iv !== 1'b1 || on !== 8'd64) begin
      n_fail++; $display("FAIL ign_result actual=%b/%0d required=1/64", iv, on);
    end
    n_checks++;
    if (bo !== 1'b1) begin n_fail++; $display("FAIL ign_busy actual=%b required=1", bo); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_x0();
    test_xor_and_ones();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
